// File: rtl/uart_word_rx.sv
// uart_word_rx: 8N1 UART receiver that packs four bytes little-endian into a 32-bit word.
// Optional inter-byte timeout enabled by defining UART_WORD_TIMEOUT_EN.
module uart_word_rx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        i_clk,
  input  logic        n_rst,
  input  logic        i_rx,
  output logic [31:0] uart_buf,
  output logic        valid_data,
  output logic        framing_err,
  output logic [1:0]  byte_idx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, nxt;
  logic          rx_m, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [31:0]   shadow;
  logic          fe_wait;
  logic          tick;
  logic          timeout;

  assign tick = cnt == ((state == START) ? HALF_M1 : FULL_M1);

  // two-flop synchronizer on the asynchronous serial line, idle high
  always_ff @(posedge i_clk or negedge n_rst)
    if (!n_rst) {rx_m, rx_s} <= 2'b11;
    else {rx_m, rx_s} <= {i_rx, rx_m};

  // state register
  always_ff @(posedge i_clk or negedge n_rst)
    if (!n_rst) state <= IDLE;
    else state <= nxt;

  // next state; after a framing error STOP waits for the line to return high
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = rx_s ? IDLE : START;
      START:   nxt = !tick ? START : (rx_s ? IDLE : DATA);
      DATA:    nxt = (tick && bit_cnt == 3'd7) ? STOP : DATA;
      STOP:    nxt = (fe_wait ? rx_s : (tick && rx_s)) ? IDLE : STOP;
      default: nxt = IDLE;
    endcase
  end

  // bit-period counter: held at zero in IDLE, reloads at every sample point
  always_ff @(posedge i_clk or negedge n_rst)
    if (!n_rst) cnt <= '0;
    else cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;

  // data path: bit shifting, byte assembly and word hand-off
  always_ff @(posedge i_clk or negedge n_rst)
    if (!n_rst) begin
      bit_cnt     <= '0;
      shift       <= '0;
      shadow      <= '0;
      uart_buf    <= '0;
      valid_data  <= 1'b0;
      framing_err <= 1'b0;
      byte_idx    <= '0;
      fe_wait     <= 1'b0;
    end else begin
      valid_data  <= 1'b0;
      framing_err <= 1'b0;
      if (state == IDLE) bit_cnt <= '0;
      if (state == DATA && tick) begin
        shift   <= {rx_s, shift[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == STOP && fe_wait && rx_s) fe_wait <= 1'b0;
      if (state == STOP && !fe_wait && tick) begin
        if (rx_s) begin
          shadow[{byte_idx, 3'b000} +: 8] <= shift;
          byte_idx <= byte_idx + 1'b1;
          if (byte_idx == 2'd3) begin
            uart_buf   <= {shift, shadow[23:0]};
            valid_data <= 1'b1;
          end
        end else begin
          framing_err <= 1'b1;
          byte_idx    <= '0;
          fe_wait     <= 1'b1;
        end
      end
      if (timeout) byte_idx <= '0;
    end

`ifdef UART_WORD_TIMEOUT_EN
  localparam int TLIM = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TLIM + 1);
  logic [TW-1:0] tcnt;

  // idle-gap counter, runs only while a partial word is pending
  always_ff @(posedge i_clk or negedge n_rst)
    if (!n_rst) tcnt <= '0;
    else tcnt <= (state != IDLE || byte_idx == 2'd0 || timeout) ? '0 : tcnt + 1'b1;

  assign timeout = tcnt == TW'(TLIM);
`else
  assign timeout = TIMEOUT_BITS < 0;
`endif
endmodule

// File: tb/tb_uart_word_rx.sv
// tb_uart_word_rx: scoreboard bench for uart_word_rx with CLKS_PER_BIT=16.
module tb_uart_word_rx;
  localparam int CPB = 16;

  logic        i_clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        i_rx = 1'b1;
  logic [31:0] uart_buf;
  logic        valid_data;
  logic        framing_err;
  logic [1:0]  byte_idx;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          fe_exp = 0;
  logic        prev_valid = 1'b0;
  logic        prev_fe = 1'b0;

  uart_word_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(20)) dut (
    .i_clk(i_clk),
    .n_rst(n_rst),
    .i_rx(i_rx),
    .uart_buf(uart_buf),
    .valid_data(valid_data),
    .framing_err(framing_err),
    .byte_idx(byte_idx)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit stop = 1'b1);
    i_rx = 1'b0;
    repeat (CPB) @(negedge i_clk);
    for (int k = 0; k < 8; k++) begin
      i_rx = b[k];
      repeat (CPB) @(negedge i_clk);
    end
    i_rx = stop;
    repeat (CPB) @(negedge i_clk);
    i_rx = 1'b1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || fe_exp != 0) && n < 400) begin
      @(negedge i_clk);
      n++;
    end
    chk(name, 32'(exp_q.size() + fe_exp), 32'd0);
  endtask

  // monitor: pops expected words on valid_data and checks pulse rules
  always @(negedge i_clk) begin
    if (n_rst) begin
      if (valid_data) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got uart_buf %h with no word expected", uart_buf);
        end else begin
          chk("uart_buf", uart_buf, exp_q.pop_front());
          chk("byte_idx_at_valid", 32'(byte_idx), 32'd0);
        end
        chk("valid_single_cycle", 32'(prev_valid), 32'd0);
        chk("valid_with_ferr", 32'(framing_err), 32'd0);
      end
      if (framing_err) begin
        if (fe_exp == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ferr: got framing_err 1 expected 0");
        end else begin
          fe_exp--;
          chk("byte_idx_at_ferr", 32'(byte_idx), 32'd0);
        end
        chk("ferr_single_cycle", 32'(prev_fe), 32'd0);
      end
    end
    prev_valid = valid_data;
    prev_fe = framing_err;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge i_clk);
    chk("rst_uart_buf", uart_buf, 32'd0);
    chk("rst_valid", 32'(valid_data), 32'd0);
    chk("rst_ferr", 32'(framing_err), 32'd0);
    chk("rst_byte_idx", 32'(byte_idx), 32'd0);
    n_rst = 1'b1;
    repeat (4) @(negedge i_clk);

    exp_q.push_back(32'h12345678);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    drain("word_12345678");
    chk("idx_after_word", 32'(byte_idx), 32'd0);

    send(8'h99);
    chk("idx_after_99", 32'(byte_idx), 32'd1);
    fe_exp = 1;
    send(8'hAA, 1'b0);
    repeat (2 * CPB) @(negedge i_clk);
    drain("ferr_pulse");
    chk("idx_after_ferr", 32'(byte_idx), 32'd0);
    chk("buf_after_ferr", uart_buf, 32'h12345678);

    send(8'h5A);
    i_rx = 1'b0;
    repeat (4) @(negedge i_clk);
    i_rx = 1'b1;
    repeat (3 * CPB) @(negedge i_clk);
    chk("idx_after_glitch", 32'(byte_idx), 32'd1);
    exp_q.push_back(32'h8D7C6B5A);
    send(8'h6B); send(8'h7C); send(8'h8D);
    drain("word_after_glitch");

    send(8'hE1); send(8'hE2);
    chk("idx_before_reset", 32'(byte_idx), 32'd2);
    n_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("buf_in_reset", uart_buf, 32'd0);
    chk("idx_in_reset", 32'(byte_idx), 32'd0);
    n_rst = 1'b1;
    repeat (CPB) @(negedge i_clk);
    exp_q.push_back(32'h04030201);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    drain("word_after_reset");

    exp_q.push_back(32'h03020100);
    exp_q.push_back(32'h07060504);
    for (int k = 0; k < 8; k++) send(8'(k));
    drain("back_to_back");

    send(8'h11); send(8'h22);
    repeat (25 * CPB) @(negedge i_clk);
`ifdef UART_WORD_TIMEOUT_EN
    exp_q.push_back(32'hAABBCCDD);
    send(8'hDD); send(8'hCC); send(8'hBB); send(8'hAA);
    drain("timeout_word");
    chk("timeout_idx", 32'(byte_idx), 32'd0);
    chk("timeout_buf", uart_buf, 32'hAABBCCDD);
`else
    exp_q.push_back(32'hCCDD2211);
    send(8'hDD); send(8'hCC); send(8'hBB); send(8'hAA);
    drain("retained_word");
    chk("retained_idx", 32'(byte_idx), 32'd2);
    chk("retained_buf", uart_buf, 32'hCCDD2211);
`endif
    repeat (4) @(negedge i_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
